// File: rtl/operand_sequencer.sv
// Multicycle operand-select sequencer: walks one decoded instruction class through
// EXEC / MEM_REQ / MEM_WAIT / WB, driving the operand mux code, write strobes and LSU handshake.
module operand_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_in_valid,
   output logic       io_in_ready,
   input  logic [2:0] io_in_op,
   output logic [2:0] io_data_control,
   output logic       io_reg_wen,
   output logic       io_pc_wen,
   output logic       io_mem_req_valid,
   input  logic       io_mem_req_ready,
   output logic       io_mem_is_store,
   input  logic       io_mem_resp_valid,
   output logic       io_done,
   output logic       io_err
);

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB} state_t;

   localparam logic [2:0] OP_IMM = 3'd0, OP_PCREL = 3'd1, OP_LOAD = 3'd2,
                          OP_OP  = 3'd3, OP_STORE = 3'd4, OP_BRANCH = 3'd5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_nxt;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic             in_mem;
   logic             timeout;

   assign in_mem  = (state == S_MEM_REQ) || (state == S_MEM_WAIT);
   // >= rather than == so a handshake landing on the last allowed cycle still bounds MEM_WAIT
   assign timeout = (cnt >= CNT_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         op_q  <= 3'd0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && io_in_valid)
            op_q <= io_in_op;
         if (state == S_EXEC)
            cnt <= '0;
         else if (in_mem && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt        = state;
      io_in_ready      = 1'b0;
      io_data_control  = 3'd0;
      io_reg_wen       = 1'b0;
      io_pc_wen        = 1'b0;
      io_mem_req_valid = 1'b0;
      io_mem_is_store  = 1'b0;
      io_done          = 1'b0;
      io_err           = 1'b0;
      case (state)
         S_IDLE: begin
            io_in_ready = reset;
            if (io_in_valid) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            state_nxt = S_IDLE;
            case (op_q)
               OP_IMM, OP_PCREL, OP_OP: begin
                  io_data_control = (op_q == OP_PCREL) ? 3'd1 : (op_q == OP_OP) ? 3'd3 : 3'd0;
                  io_reg_wen      = 1'b1;
                  io_pc_wen       = 1'b1;
                  io_done         = 1'b1;
               end
               OP_BRANCH: begin
                  io_data_control = 3'd3;
                  io_pc_wen       = 1'b1;
                  io_done         = 1'b1;
               end
               OP_LOAD, OP_STORE: state_nxt = S_MEM_REQ;
               default: begin
                  io_done = 1'b1;
                  io_err  = 1'b1;
               end
            endcase
         end
         S_MEM_REQ: begin
            io_mem_req_valid = 1'b1;
            io_mem_is_store  = (op_q == OP_STORE);
            if (io_mem_req_ready)
               state_nxt = S_MEM_WAIT;
            else if (timeout) begin
               io_done   = 1'b1;
               io_err    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_MEM_WAIT: begin
            if (io_mem_resp_valid) begin
               if (op_q == OP_STORE) begin
                  io_pc_wen = 1'b1;
                  io_done   = 1'b1;
                  state_nxt = S_IDLE;
               end else
                  state_nxt = S_WB;
            end else if (timeout) begin
               io_done   = 1'b1;
               io_err    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WB: begin
            io_data_control = 3'd2;
            io_reg_wen      = 1'b1;
            io_pc_wen       = 1'b1;
            io_done         = 1'b1;
            state_nxt       = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: vector table for single-cycle classes, hand sequences for
// memory/timeout/reset corners, and randomized memory timing against an outcome model.
module tb_operand_sequencer;
   localparam int TO = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       io_in_valid, io_in_ready;
   logic [2:0] io_in_op, io_data_control;
   logic       io_reg_wen, io_pc_wen, io_mem_req_valid, io_mem_req_ready;
   logic       io_mem_is_store, io_mem_resp_valid, io_done, io_err;

   int tests = 0, fails = 0;
   int s_ready, s_dc, s_reg, s_pc, s_req, s_st, s_done, s_err;

   always #5 clock = ~clock;

   operand_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_op(io_in_op),
      .io_data_control(io_data_control), .io_reg_wen(io_reg_wen), .io_pc_wen(io_pc_wen),
      .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
      .io_mem_is_store(io_mem_is_store), .io_mem_resp_valid(io_mem_resp_valid),
      .io_done(io_done), .io_err(io_err)
   );

   // sample the current cycle's outputs (inputs already driven), then advance one clock
   task automatic tick();
      #1;
      s_ready = int'(io_in_ready);  s_dc = int'(io_data_control);
      s_reg   = int'(io_reg_wen);   s_pc = int'(io_pc_wen);
      s_req   = int'(io_mem_req_valid); s_st = int'(io_mem_is_store);
      s_done  = int'(io_done);      s_err = int'(io_err);
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic accept(input logic [2:0] op);
      io_in_valid = 1'b1;
      io_in_op    = op;
      tick();
      chk("accept_ready", s_ready, 1);
      io_in_valid = 1'b0;
   endtask

   typedef struct {
      logic [2:0] op;
      int dc, rw, pw, er;
   } vec_t;

   vec_t vt[6];

   // expected outcome of one instruction, from the class rules and memory timing
   task automatic model(input int op, input int dr, input int ds,
                        output int done_k, output int err, output int rw, output int pw,
                        output int dc);
      int r;
      err = 0; rw = 0; pw = 0; dc = 0; done_k = 1;
      case (op)
         0, 1, 3: begin rw = 1; pw = 1; dc = (op == 1) ? 1 : (op == 3) ? 3 : 0; end
         5:       begin pw = 1; dc = 3; end
         2, 4: begin
            r = (ds < 0) ? 1000 : dr + 1 + ds;   // index of resp within the memory phase
            if (dr >= TO || r > TO - 1) begin
               done_k = 2 + TO - 1;
               err = 1;
            end else if (op == 2) begin
               done_k = 3 + r; rw = 1; pw = 1; dc = 2;
            end else begin
               done_k = 2 + r; pw = 1;
            end
         end
         default: begin err = 1; dc = -1; end
      endcase
   endtask

   initial begin
      int drl[5];
      int op, dr, ds, e_k, e_err, e_rw, e_pw, e_dc;
      int got_k, got_err, got_dc, n_done, n_rw, n_pw;

      vt[0] = '{3'd0, 0, 1, 1, 0};
      vt[1] = '{3'd1, 1, 1, 1, 0};
      vt[2] = '{3'd3, 3, 1, 1, 0};
      vt[3] = '{3'd5, 3, 0, 1, 0};
      vt[4] = '{3'd6, -1, 0, 0, 1};
      vt[5] = '{3'd7, -1, 0, 0, 1};
      drl = '{0, 1, 2, 4, 6};

      // reset held with a pending instruction
      reset = 1'b0; io_in_valid = 1'b1; io_in_op = 3'd3;
      io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0;
      repeat (3) tick();
      chk("rst_ready", s_ready, 0);
      chk("rst_outs", s_dc + s_reg + s_pc + s_req + s_st + s_done + s_err, 0);
      io_in_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("rst_release_ready", s_ready, 1);

      for (int i = 0; i < 6; i++) begin
         accept(vt[i].op);
         tick();
         if (vt[i].dc >= 0) chk($sformatf("vec%0d_dc", i), s_dc, vt[i].dc);
         chk($sformatf("vec%0d_reg_wen", i), s_reg, vt[i].rw);
         chk($sformatf("vec%0d_pc_wen", i), s_pc, vt[i].pw);
         chk($sformatf("vec%0d_done", i), s_done, 1);
         chk($sformatf("vec%0d_err", i), s_err, vt[i].er);
         chk($sformatf("vec%0d_req", i), s_req, 0);
         tick();
         chk($sformatf("vec%0d_ready_after", i), s_ready, 1);
      end

      // load, ready immediate, response in the second wait cycle
      accept(3'd2);
      tick();
      chk("ld_exec_quiet", s_reg + s_pc + s_done, 0);
      io_mem_req_ready = 1'b1; tick(); io_mem_req_ready = 1'b0;
      chk("ld_req_valid", s_req, 1);
      chk("ld_is_store", s_st, 0);
      tick();
      chk("ld_wait_req_low", s_req + s_done, 0);
      io_mem_resp_valid = 1'b1; tick(); io_mem_resp_valid = 1'b0;
      chk("ld_resp_cycle_done", s_done, 0);
      tick();
      chk("ld_wb_dc", s_dc, 2);
      chk("ld_wb_strobes", s_reg + s_pc + s_done, 3);
      chk("ld_wb_err", s_err, 0);
      tick();
      chk("ld_ready_after", s_ready, 1);

      // store with ready withheld for 3 cycles
      accept(3'd4);
      tick();
      for (int k = 0; k < 4; k++) begin
         io_mem_req_ready = (k == 3);
         tick();
         chk($sformatf("st_req_valid%0d", k), s_req, 1);
         chk($sformatf("st_is_store%0d", k), s_st, 1);
         chk($sformatf("st_no_done%0d", k), s_done, 0);
      end
      io_mem_req_ready = 1'b0;
      io_mem_resp_valid = 1'b1; tick(); io_mem_resp_valid = 1'b0;
      chk("st_done", s_done, 1);
      chk("st_pc_wen", s_pc, 1);
      chk("st_reg_wen", s_reg, 0);
      chk("st_err", s_err, 0);

      // timeout with no response, then response on the timeout cycle
      for (int rep = 0; rep < 2; rep++) begin
         accept(3'd2);
         tick();
         for (int k = 0; k < TO; k++) begin
            io_mem_req_ready  = (k == 0);
            io_mem_resp_valid = (rep == 1 && k == TO - 1);
            tick();
            chk($sformatf("to%0d_done_k%0d", rep, k), s_done, (rep == 0 && k == TO - 1) ? 1 : 0);
            chk($sformatf("to%0d_err_k%0d", rep, k), s_err, (rep == 0 && k == TO - 1) ? 1 : 0);
         end
         io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0;
         tick();
         if (rep == 0) chk("to0_idle_after", s_ready, 1);
         else begin
            chk("to1_wb_done", s_done, 1);
            chk("to1_wb_err", s_err, 0);
            chk("to1_wb_reg", s_reg, 1);
            tick();
         end
      end

      // reset pulse in MEM_WAIT, late response must be ignored
      accept(3'd2);
      tick();
      io_mem_req_ready = 1'b1; tick(); io_mem_req_ready = 1'b0;
      reset = 1'b0;
      #2;
      chk("midrst_ready", int'(io_in_ready), 0);
      chk("midrst_outs", int'(io_done) + int'(io_reg_wen) + int'(io_pc_wen) + int'(io_mem_req_valid), 0);
      reset = 1'b1;
      io_mem_resp_valid = 1'b1; tick(); io_mem_resp_valid = 1'b0;
      chk("midrst_late_resp_done", s_done, 0);
      chk("midrst_idle", s_ready, 1);
      tick();
      chk("midrst_no_wb", s_done + s_reg, 0);

      // randomized classes and memory timing
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 7);
         dr = drl[$urandom_range(0, 4)];
         ds = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 3);
         model(op, dr, ds, e_k, e_err, e_rw, e_pw, e_dc);
         accept(op[2:0]);
         got_k = -1; got_err = 0; got_dc = 0; n_done = 0; n_rw = 0; n_pw = 0;
         for (int k = 1; k <= 10; k++) begin
            io_mem_req_ready  = (k == 2 + dr);
            io_mem_resp_valid = (ds >= 0 && k == 3 + dr + ds);
            tick();
            n_done += s_done; n_rw += s_reg; n_pw += s_pc;
            if (s_done == 1 && got_k < 0) begin
               got_k = k; got_err = s_err; got_dc = s_dc;
            end
         end
         io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0;
         chk($sformatf("rnd%0d_op%0d_done_cycle", it, op), got_k, e_k);
         chk($sformatf("rnd%0d_op%0d_done_count", it, op), n_done, 1);
         chk($sformatf("rnd%0d_op%0d_err", it, op), got_err, e_err);
         chk($sformatf("rnd%0d_op%0d_reg_wen", it, op), n_rw, e_rw);
         chk($sformatf("rnd%0d_op%0d_pc_wen", it, op), n_pw, e_pw);
         if (e_dc >= 0) chk($sformatf("rnd%0d_op%0d_dc", it, op), got_dc, e_dc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
